// File: rtl/bcd_countdown.sv
// Multi-digit BCD countdown timer: load, start/pause/resume, one decrement per PRESCALE cycles.
// All outputs registered except zero; done pulses for one cycle on reaching 0.
module bcd_countdown #(
  parameter int DIGITS   = 2,
  parameter int PRESCALE = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_value,
  input  logic                start,
  input  logic                pause,
  output logic [4*DIGITS-1:0] cnt,
  output logic                running,
  output logic                zero,
  output logic                done
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]  pre_q, pre_d;
  logic           done_q, done_d;
  logic           running_q, running_d;

  function automatic logic [W-1:0] bcd_sanitise(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  // Borrow ripples upward through zero digits, which become 9.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    done_d  = 1'b0;
    if (load) begin
      cnt_d   = bcd_sanitise(load_value);
      pre_d   = '0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && (cnt_q != '0)) begin
            state_d = RUN;
            pre_d   = '0;
          end
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSED;
          end else if (pre_q == PRE_MAX) begin
            pre_d = '0;
            cnt_d = bcd_dec(cnt_q);
            if (cnt_q == W'(1)) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end else begin
            pre_d = pre_q + PW'(1);
          end
        end
        PAUSED: begin
          if (start && !pause) state_d = RUN;
        end
        default: ;
      endcase
    end
    running_d = (state_d == RUN);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pre_q     <= '0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pre_q     <= pre_d;
      done_q    <= done_d;
      running_q <= running_d;
    end
  end

  assign cnt     = cnt_q;
  assign running = running_q;
  assign done    = done_q;
  assign zero    = (cnt_q == '0);

endmodule

// File: doc/bcd_countdown.md
Name: bcd_countdown

Overview:
- Multi-digit BCD down-counter (countdown timer). It is the decrementing counterpart of the team's mod-10 up-counter.
- Loaded with a BCD value, started, then decrements once per prescaled tick, borrowing digit to digit, until it reaches zero.
- Used as a timer/sequence source in simulation examples and display-driving designs. Outputs feed 7-segment decoders per digit.

Parameters:
- DIGITS, 2, number of BCD digits; counter width is 4*DIGITS.
- PRESCALE, 1, clock cycles per decrement tick (>=1); 1 means decrement every cycle while running.

Ports:
- clock  input  1  sole clock, all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- load  input  1  load load_value, go to IDLE.
- load_value  input  4*DIGITS  BCD preset, digit 0 in bits [3:0].
- start  input  1  begin/resume counting.
- pause  input  1  suspend counting.
- cnt  output  4*DIGITS  current BCD count (registered).
- running  output  1  high while in RUN.
- zero  output  1  high when cnt == 0 (combinational from cnt).
- done  output  1  one-cycle pulse when count reaches 0.

Behaviour:
- Reset (reset_n low, asynchronous): cnt=0, prescaler=0, state=IDLE, running=0, done=0, zero=1.
- States and transitions:
  - IDLE: start && cnt!=0 -> RUN. start with cnt==0 is ignored.
  - RUN: count runs. pause -> PAUSE. Reaching 0 -> DONE.
  - PAUSE: start && !pause -> RUN. Prescaler and cnt hold.
  - DONE: cnt holds 0. start is ignored. Only load leaves this state.
- Priority, highest first: reset_n, then load, then pause, then start.
- load in any state: cnt <= load_value, prescaler <= 0, state <= IDLE, done <= 0.
- Digit sanitising on load: any digit >9 is loaded as 9.
- Prescaler in RUN: counts 0..PRESCALE-1. A tick occurs in the cycle where prescaler==PRESCALE-1; the prescaler then wraps to 0.
- Decrement on tick:
  - Digit 0 decrements by 1.
  - Any digit at 0 that receives a borrow becomes 9 and passes the borrow to the next digit up.
  - No binary wrap: results are always valid BCD.
- Reaching zero: on the tick edge where cnt goes from 1 to 0, the same edge sets state <= DONE and done <= 1. done returns to 0 on the next edge.
- First decrement timing: the first decrement occurs PRESCALE cycles after the edge on which state becomes RUN.
- running is registered and equals (state==RUN).
- pause and start together in RUN: pause wins, state goes to PAUSE. In PAUSE: stays PAUSE.
- pause in IDLE or DONE: ignored.
- load in the same cycle as a tick: load wins, no decrement, no done pulse.
- Reset mid-count: immediate clear to reset values. No done pulse.
- All outputs are glitch-free registers except zero.

Test Plan:
All scenarios use DIGITS=2 and a 100 ns clock unless stated. Check values on the negedge.
1. Reset then idle: reset_n=0 for 100 ns, then release -> cnt=8'h00, zero=1, running=0, done=0. Pulse start -> state stays IDLE, running=0.
2. Borrow chain, PRESCALE=1:
   - load 8'h12, then pulse start -> running=1.
   - cnt sequence on successive negedges: 11,10,09,08,...,01,00.
   - done=1 exactly in the cycle cnt first reads 00; then done=0, running=0, zero=1.
3. Load sanitising: load_value=8'hAF -> cnt=8'h99. start -> next values 98, 97.
4. Pause/resume, PRESCALE=3:
   - load 8'h05, start -> cnt changes to 04 after 3 cycles.
   - Assert pause for 5 cycles -> cnt stays 04, running=0.
   - start -> 03 after 3 more cycles.
   - pause and start together in RUN -> PAUSE.
5. Priority collisions, PRESCALE=1:
   - load 8'h02 in the same cycle as the tick that would reach 00 -> cnt=02, state IDLE, no done pulse.
   - Assert reset_n=0 asynchronously mid-count, away from a clock edge -> cnt=00 immediately, done never asserts.
6. DONE holding: after reaching 00, pulse start and pause -> cnt stays 00, no further done pulses. load 8'h01 + start -> done pulses once one cycle later.
